// File: rtl/mul_div_unit_if.sv
// Request/response bus of mul_div_unit: one request channel (op, a, b)
// and one result channel, each with a valid/ready handshake.
interface mul_div_unit_if #(
  parameter int unsigned N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;

  // Requester side: issues operations and consumes results
  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result
  );

  // Unit side
  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RISC-V style multiply/divide unit (MUL, MULH, MULHSU, MULHU,
// DIV, DIVU, REM, REMU). One shift-add or restoring-subtract step per cycle.
// Optional feature macro MULDIV_FAST_MUL_EN: multiplies use a single-cycle
// combinational multiplier instead of the iterative datapath.
module mul_div_unit #(
  parameter int unsigned N = 32
) (
  input logic          clk,
  input logic          rst,
  mul_div_unit_if.slave bus
);

  localparam int unsigned CW = $clog2(N);
  localparam logic [N-1:0] MinNeg = {1'b1, {(N - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic [2:0]     op_q;
  logic [N-1:0]   hi_q;      // product high half / partial remainder
  logic [N-1:0]   lo_q;      // multiplier bits / quotient bits / early result
  logic [N-1:0]   opnd_q;    // multiplicand / divisor magnitude
  logic           neg_q;     // negate product or quotient at the end
  logic           neg_rem_q; // negate remainder at the end
  logic           short_q;   // result already in lo_q, finish next cycle
  logic           in_ready_q;
  logic           out_valid_q;
  logic [N-1:0]   result_q;

  // Request decode: signedness, magnitudes and early-out cases
  logic         a_sgn, b_sgn, a_neg, b_neg, is_div;
  logic [N-1:0] a_mag, b_mag;
  logic         div_zero, div_ovf;
  logic [N-1:0] special_res;

  assign is_div   = bus.op[2];
  assign a_sgn    = (bus.op == 3'd1) || (bus.op == 3'd2) || (bus.op == 3'd4) || (bus.op == 3'd6);
  assign b_sgn    = (bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd6);
  assign a_neg    = a_sgn & bus.a[N-1];
  assign b_neg    = b_sgn & bus.b[N-1];
  assign a_mag    = a_neg ? -bus.a : bus.a;
  assign b_mag    = b_neg ? -bus.b : bus.b;
  assign div_zero = (bus.b == '0);
  assign div_ovf  = ((bus.op == 3'd4) || (bus.op == 3'd6)) && (bus.a == MinNeg) &&
                    (bus.b == '1);
  // op[1] separates REM/REMU from DIV/DIVU
  assign special_res = div_zero ? (bus.op[1] ? bus.a : '1)
                                : (bus.op[1] ? '0 : bus.a);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*N-1:0] fast_mag, fast_s;
  logic [N-1:0]   fast_res;

  assign fast_mag = {{N{1'b0}}, a_mag} * {{N{1'b0}}, b_mag};
  assign fast_s   = (a_neg ^ b_neg) ? -fast_mag : fast_mag;
  assign fast_res = (bus.op[1:0] == 2'd0) ? fast_s[N-1:0] : fast_s[2*N-1:N];
`endif

  // One iteration step of each datapath
  logic [N:0]     mul_sum;
  logic [N:0]     div_sh, div_diff;
  logic           div_ge;
  logic [N-1:0]   it_hi, it_lo;

  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(N + 1){1'b0}});
  assign div_sh   = {hi_q, lo_q[N-1]};
  assign div_diff = div_sh - {1'b0, opnd_q};
  assign div_ge   = ~div_diff[N];
  assign it_hi    = op_q[2] ? (div_ge ? div_diff[N-1:0] : div_sh[N-1:0]) : mul_sum[N:1];
  assign it_lo    = op_q[2] ? {lo_q[N-2:0], div_ge} : {mul_sum[0], lo_q[N-1:1]};

  // Sign fix-up and result selection after the last step
  logic [2*N-1:0] prod, prod_s;
  logic [N-1:0]   quot, rem, fin;

  assign prod   = {it_hi, it_lo};
  assign prod_s = neg_q ? -prod : prod;
  assign quot   = neg_q ? -it_lo : it_lo;
  assign rem    = neg_rem_q ? -it_hi : it_hi;
  assign fin    = op_q[2] ? (op_q[1] ? rem : quot)
                          : ((op_q[1:0] == 2'd0) ? prod_s[N-1:0] : prod_s[2*N-1:N]);

  // Control FSM with registered handshake outputs and result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_q        <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
      neg_q       <= 1'b0;
      neg_rem_q   <= 1'b0;
      short_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            state_q    <= StCalc;
            in_ready_q <= 1'b0;
            op_q       <= bus.op;
            cnt_q      <= '0;
            neg_q      <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            hi_q       <= '0;
            if (is_div && (div_zero || div_ovf)) begin
              lo_q    <= special_res;
              short_q <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!is_div) begin
              lo_q    <= fast_res;
              short_q <= 1'b1;
`endif
            end else begin
              // Divide: lo holds dividend; multiply: lo holds multiplier
              lo_q    <= is_div ? a_mag : b_mag;
              opnd_q  <= is_div ? b_mag : a_mag;
              short_q <= 1'b0;
            end
          end
        end
        StCalc: begin
          if (short_q) begin
            result_q    <= lo_q;
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end else begin
            hi_q  <= it_hi;
            lo_q  <= it_lo;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(N - 1)) begin
              result_q    <= fin;
              state_q     <= StDone;
              out_valid_q <= 1'b1;
            end
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

endmodule
